mac_mii_tx_gen: RTL and testbench

Synthesizable, parametrised MII/GMII transmit frame generator.
- Replaces the behavioural TX stimulus driver with RTL usable on FPGA and in regression.
- On a start request it emits a complete Ethernet frame on the MAC-side TX interface: preamble, SFD, pattern payload, optional FCS, then the inter-frame gap.
- Supports nibble (MII) and byte (GMII) data paths; a clock-enable handles 10/100 pacing.

---
 rtl/mac_tx_pkg.sv | 26 ++
 rtl/mac_crc32_byte.sv | 25 ++
 rtl/mac_mii_tx_gen.sv | 202 ++++++++++++++++++++
 tb/tb_mac_mii_tx_gen.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_tx_pkg.sv
// Shared types and constants for the MII/GMII transmit frame generator.
// Holds the TX state encoding, framing bytes and CRC-32 constants.
// Pure declarations: no logic, no latency, no backpressure.
package mac_tx_pkg;

  typedef enum logic [2:0] {IDLE, PRE, SFD, PAY, FCS, IFG} tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 7;
  localparam int          FCS_LEN       = 4;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  // Bit-reverse a 32-bit word; turns the normal polynomial into the LSB-first form.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_crc32_byte.sv
// One-byte update of the reflected Ethernet CRC-32 (LSB-first bit order).
// Purely combinational: zero latency.
// No handshake; the caller decides when to register the result.
module mac_crc32_byte
  import mac_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

  logic [31:0] c;

  // Shift the byte through the CRC register one bit at a time, LSB first.
  always_comb begin
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/mac_mii_tx_gen.sv
// MII/GMII TX frame generator: preamble, SFD, seed+k payload, optional FCS, IFG.
// Latency: first preamble beat appears one ce edge after a pending request is seen in IDLE.
// No backpressure; ce_i paces every beat and requests are dropped while busy. FCS: `MAC_TX_FCS_EN.
module mac_mii_tx_gen
  import mac_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_LEN   = 1500,
  parameter int IFG_BYTES = 12,
  parameter int LEN_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ce_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [7:0]        seed_i,
  output logic              mac_mii_tx_dv_o,
  output logic [DATA_W-1:0] mac_mii_txd_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       frame_cnt_o
);

  // One counter serves preamble, payload, FCS and IFG byte indices.
  localparam int LEN_CW = $clog2(MAX_LEN + 1);
  localparam int IFG_CW = $clog2(IFG_BYTES + 1);
  localparam int MAX_CW = (LEN_CW > IFG_CW) ? LEN_CW : IFG_CW;
  localparam int CNT_W  = (MAX_CW > 3) ? MAX_CW : 3;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_last;
  logic [7:0]       seed_q;
  logic [7:0]       cur_byte;   // byte currently on the wire (IFG holds zero)
  logic             nib;        // 1 while the high nibble is on the wire (MII only)
  logic             pending;
  logic             byte_last;

  assign len_last  = len_q - CNT_W'(1);
  // In byte mode every beat completes a byte; in nibble mode only the high-nibble beat does.
  assign byte_last = (DATA_W == 8) || nib;

  function automatic logic [DATA_W-1:0] lo_beat(input logic [7:0] b);
    return b[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] hi_beat(input logic [7:0] b);
    return b[7 -: DATA_W];
  endfunction

`ifdef MAC_TX_FCS_EN
  logic [31:0] crc_q;
  logic [31:0] crc_nx;
  logic [7:0]  fcs_first;
  logic [7:0]  fcs_next;

  mac_crc32_byte u_crc (
    .crc      (crc_q),
    .data     (cur_byte),
    .crc_next (crc_nx)
  );

  // FCS is the complemented CRC, shifted out LS byte first.
  assign fcs_first = ~crc_nx[7:0];
  assign fcs_next  = ~crc_q[15:8];
`endif

  // Frame FSM: request capture, beat sequencing and registered TX outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      len_q           <= '0;
      seed_q          <= '0;
      cur_byte        <= '0;
      nib             <= 1'b0;
      pending         <= 1'b0;
      mac_mii_tx_dv_o <= 1'b0;
      mac_mii_txd_o   <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      frame_cnt_o     <= '0;
`ifdef MAC_TX_FCS_EN
      crc_q           <= CRC32_INIT;
`endif
    end else begin
      // done is a single-clock pulse even when ce_i is slow.
      done_o <= 1'b0;

      if (start_i && !busy_o && !pending && (len_i != '0)) begin
        pending <= 1'b1;
      end

      if (ce_i) begin
        if (state == IDLE) begin
          if (pending) begin
            pending         <= 1'b0;
            busy_o          <= 1'b1;
            state           <= PRE;
            cnt             <= '0;
            nib             <= 1'b0;
            seed_q          <= seed_i;
            len_q           <= (32'(len_i) > 32'(MAX_LEN)) ? CNT_W'(MAX_LEN) : CNT_W'(len_i);
            cur_byte        <= PREAMBLE_BYTE;
            mac_mii_tx_dv_o <= 1'b1;
            mac_mii_txd_o   <= lo_beat(PREAMBLE_BYTE);
          end
        end else if (!byte_last) begin
          // Second half of an MII byte: same byte, upper nibble.
          nib           <= 1'b1;
          mac_mii_txd_o <= hi_beat(cur_byte);
        end else begin
          nib <= 1'b0;
          case (state)
            PRE: begin
              if (cnt == PRE_LAST) begin
                state         <= SFD;
                cnt           <= '0;
                cur_byte      <= SFD_BYTE;
                mac_mii_txd_o <= lo_beat(SFD_BYTE);
`ifdef MAC_TX_FCS_EN
                crc_q         <= CRC32_INIT;
`endif
              end else begin
                cnt           <= cnt + CNT_W'(1);
                mac_mii_txd_o <= lo_beat(PREAMBLE_BYTE);
              end
            end
            SFD: begin
              state         <= PAY;
              cnt           <= '0;
              cur_byte      <= seed_q;
              mac_mii_txd_o <= lo_beat(seed_q);
            end
            PAY: begin
`ifdef MAC_TX_FCS_EN
              crc_q <= crc_nx;
`endif
              if (cnt == len_last) begin
                cnt <= '0;
`ifdef MAC_TX_FCS_EN
                state           <= FCS;
                cur_byte        <= fcs_first;
                mac_mii_txd_o   <= lo_beat(fcs_first);
`else
                state           <= IFG;
                cur_byte        <= 8'h00;
                mac_mii_tx_dv_o <= 1'b0;
                mac_mii_txd_o   <= '0;
`endif
              end else begin
                cnt           <= cnt + CNT_W'(1);
                cur_byte      <= cur_byte + 8'd1;
                mac_mii_txd_o <= lo_beat(cur_byte + 8'd1);
              end
            end
`ifdef MAC_TX_FCS_EN
            FCS: begin
              if (cnt == CNT_W'(FCS_LEN - 1)) begin
                state           <= IFG;
                cnt             <= '0;
                cur_byte        <= 8'h00;
                mac_mii_tx_dv_o <= 1'b0;
                mac_mii_txd_o   <= '0;
              end else begin
                cnt           <= cnt + CNT_W'(1);
                crc_q         <= {8'h00, crc_q[31:8]};
                cur_byte      <= fcs_next;
                mac_mii_txd_o <= lo_beat(fcs_next);
              end
            end
`endif
            IFG: begin
              if (cnt == IFG_LAST) begin
                state       <= IDLE;
                cnt         <= '0;
                busy_o      <= 1'b0;
                done_o      <= 1'b1;
                frame_cnt_o <= frame_cnt_o + 16'd1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            default: begin
              state           <= IDLE;
              cnt             <= '0;
              busy_o          <= 1'b0;
              mac_mii_tx_dv_o <= 1'b0;
              mac_mii_txd_o   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_mii_tx_gen.sv
// Scoreboarded bench for mac_mii_tx_gen: one GMII and one MII instance on a shared clock.
// Expected beats are queued at request time; negedge monitors pop and compare.
// Covers reset, ce pacing, ignored requests, reset abort, length clamp and (with `MAC_TX_FCS_EN) FCS.
module tb_mac_mii_tx_gen;

`ifdef MAC_TX_FCS_EN
  localparam int FCS_B = 4;
`else
  localparam int FCS_B = 0;
`endif
  localparam int BOUND = 6000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        g_ce, g_start, g_dv, g_busy, g_done;
  logic [15:0] g_len, g_fcnt;
  logic [7:0]  g_seed, g_txd;

  logic        m_ce, m_start, m_dv, m_busy, m_done;
  logic [15:0] m_len, m_fcnt;
  logic [7:0]  m_seed;
  logic [3:0]  m_txd;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] g_q[$];
  logic [3:0] m_q[$];

  logic g_ce_q = 1'b0;
  logic rst_q  = 1'b1;
  logic g_dv_p = 1'b0;
  logic [7:0] g_txd_p = 8'h00;
  bit   g_ce_div = 1'b0;
  int   div = 0;

  int g_dv_beats, g_ifg_beats, g_done_cnt;
  int m_dv_beats, m_ifg_beats, m_done_cnt;

  always #5 clk = ~clk;

  mac_mii_tx_gen #(.DATA_W(8)) u_gmii (
    .clk_i(clk), .rst_i(rst), .ce_i(g_ce), .start_i(g_start), .len_i(g_len), .seed_i(g_seed),
    .mac_mii_tx_dv_o(g_dv), .mac_mii_txd_o(g_txd), .busy_o(g_busy), .done_o(g_done),
    .frame_cnt_o(g_fcnt)
  );

  mac_mii_tx_gen #(.DATA_W(4)) u_mii (
    .clk_i(clk), .rst_i(rst), .ce_i(m_ce), .start_i(m_start), .len_i(m_len), .seed_i(m_seed),
    .mac_mii_tx_dv_o(m_dv), .mac_mii_txd_o(m_txd), .busy_o(m_busy), .done_o(m_done),
    .frame_cnt_o(m_fcnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

`ifdef MAC_TX_FCS_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  task automatic push_byte(input bit mii, input logic [7:0] b);
    if (mii) begin
      m_q.push_back(b[3:0]);
      m_q.push_back(b[7:4]);
    end else begin
      g_q.push_back(b);
    end
  endtask

  // Queue the whole expected frame (payload already clamped by the caller).
  task automatic push_frame(input bit mii, input int len, input logic [7:0] seed, input bit hand_fcs);
    logic [7:0]  b;
    logic [31:0] crc;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) push_byte(mii, 8'h55);
    push_byte(mii, 8'hD5);
    b = seed;
    for (int k = 0; k < len; k++) begin
`ifdef MAC_TX_FCS_EN
      crc = crc_upd(crc, b);
`endif
      push_byte(mii, b);
      b = b + 8'd1;
    end
`ifdef MAC_TX_FCS_EN
    crc = ~crc;
    if (hand_fcs) begin
      push_byte(mii, 8'h26); push_byte(mii, 8'h39); push_byte(mii, 8'hF4); push_byte(mii, 8'hCB);
    end else begin
      for (int i = 0; i < 4; i++) push_byte(mii, crc[8*i +: 8]);
    end
`else
    if (hand_fcs) crc = 32'h0;
`endif
  endtask

  task automatic clr_counts();
    g_dv_beats = 0; g_ifg_beats = 0; g_done_cnt = 0;
    m_dv_beats = 0; m_ifg_beats = 0; m_done_cnt = 0;
  endtask

  task automatic request(input bit mii, input logic [15:0] len, input logic [7:0] seed);
    @(negedge clk);
    if (mii) begin m_len = len; m_seed = seed; m_start = 1'b1; end
    else     begin g_len = len; g_seed = seed; g_start = 1'b1; end
    @(negedge clk);
    m_start = 1'b0;
    g_start = 1'b0;
  endtask

  task automatic wait_done(input bit mii, input string name);
    int t;
    bit seen;
    t = 0;
    seen = 1'b0;
    while (t < BOUND && !seen) begin
      @(negedge clk);
      t++;
      seen = mii ? m_done : g_done;
    end
    check({name, "_done_seen"}, {31'b0, seen}, 32'd1);
    @(negedge clk);
  endtask

  // Sampled at the active edge so the monitor knows whether a beat advanced.
  always @(posedge clk) begin
    g_ce_q <= g_ce;
    rst_q  <= rst;
  end

  // ce generator for the GMII instance: 1-of-10 when pacing is on.
  initial begin
    forever begin
      @(negedge clk);
      if (g_ce_div) begin
        g_ce = (div == 0);
        div  = (div + 1) % 10;
      end else begin
        g_ce = 1'b1;
        div  = 0;
      end
    end
  end

  // GMII monitor: pop on every advanced valid beat, hold-check on non-ce clocks.
  always @(negedge clk) begin
    if (!rst_q) begin
      if (g_ce_q) begin
        if (g_dv) begin
          g_dv_beats++;
          if (g_q.size() == 0) check("g_unexpected_beat_qsize", 32'(g_q.size()), 32'd1);
          else check("g_txd", {24'h0, g_txd}, {24'h0, g_q.pop_front()});
        end else begin
          check("g_txd_idle", {24'h0, g_txd}, 32'd0);
          if (g_busy) g_ifg_beats++;
        end
      end else begin
        check("g_hold_dv", {31'b0, g_dv}, {31'b0, g_dv_p});
        check("g_hold_txd", {24'h0, g_txd}, {24'h0, g_txd_p});
      end
      if (g_done) g_done_cnt++;
    end
    g_dv_p  = g_dv;
    g_txd_p = g_txd;
  end

  // MII monitor: ce is tied high, so every clock is a beat.
  always @(negedge clk) begin
    if (!rst_q) begin
      if (m_dv) begin
        m_dv_beats++;
        if (m_q.size() == 0) check("m_unexpected_beat_qsize", 32'(m_q.size()), 32'd1);
        else check("m_txd", {28'h0, m_txd}, {28'h0, m_q.pop_front()});
      end else begin
        check("m_txd_idle", {28'h0, m_txd}, 32'd0);
        if (m_busy) m_ifg_beats++;
      end
      if (m_done) m_done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit saw_busy;
    int t;
    g_ce = 1'b1; g_start = 1'b0; g_len = '0; g_seed = '0;
    m_ce = 1'b1; m_start = 1'b0; m_len = '0; m_seed = '0;
    clr_counts();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_g_dv",   {31'b0, g_dv},   32'd0);
    check("rst_g_txd",  {24'h0, g_txd},  32'd0);
    check("rst_g_busy", {31'b0, g_busy}, 32'd0);
    check("rst_g_done", {31'b0, g_done}, 32'd0);
    check("rst_g_fcnt", {16'h0, g_fcnt}, 32'd0);
    check("rst_m_dv",   {31'b0, m_dv},   32'd0);
    check("rst_m_busy", {31'b0, m_busy}, 32'd0);
    check("rst_m_fcnt", {16'h0, m_fcnt}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // GMII len=4 seed=A0
    clr_counts();
    push_frame(0, 4, 8'hA0, 0);
    request(0, 16'd4, 8'hA0);
    wait_done(0, "t1");
    check("t1_fcnt",  {16'h0, g_fcnt}, 32'd1);
    check("t1_beats", g_dv_beats, 12 + FCS_B);
    check("t1_ifg",   g_ifg_beats, 12);
    check("t1_dones", g_done_cnt, 1);
    check("t1_qleft", 32'(g_q.size()), 32'd0);

    // MII len=1 seed=3C
    clr_counts();
    push_frame(1, 1, 8'h3C, 0);
    request(1, 16'd1, 8'h3C);
    wait_done(1, "t2");
    check("t2_fcnt",  {16'h0, m_fcnt}, 32'd1);
    check("t2_beats", m_dv_beats, 18 + 2 * FCS_B);
    check("t2_ifg",   m_ifg_beats, 24);
    check("t2_dones", m_done_cnt, 1);
    check("t2_qleft", 32'(m_q.size()), 32'd0);

    // "123456789" payload; FCS bytes hand-entered when the option is built in
    clr_counts();
    push_frame(0, 9, 8'h31, 1);
    request(0, 16'd9, 8'h31);
    wait_done(0, "t3");
    check("t3_fcnt",  {16'h0, g_fcnt}, 32'd2);
    check("t3_beats", g_dv_beats, 17 + FCS_B);
    check("t3_qleft", 32'(g_q.size()), 32'd0);

    // ce 1-of-10, len=2; start while busy and start with len=0 must be ignored
    g_ce_div = 1'b1;
    clr_counts();
    push_frame(0, 2, 8'h10, 0);
    request(0, 16'd2, 8'h10);
    repeat (40) @(negedge clk);
    check("t4_busy_mid", {31'b0, g_busy}, 32'd1);
    request(0, 16'd5, 8'h99);
    wait_done(0, "t4");
    check("t4_fcnt",  {16'h0, g_fcnt}, 32'd3);
    check("t4_beats", g_dv_beats, 10 + FCS_B);
    check("t4_ifg",   g_ifg_beats, 12);
    check("t4_dones", g_done_cnt, 1);
    saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (g_busy) saw_busy = 1'b1;
    end
    check("t4_busy_req_ignored", {31'b0, saw_busy}, 32'd0);
    request(0, 16'd0, 8'h55);
    saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (g_busy) saw_busy = 1'b1;
    end
    check("t4_zero_len_ignored", {31'b0, saw_busy}, 32'd0);
    check("t4_fcnt_after", {16'h0, g_fcnt}, 32'd3);
    check("t4_qleft", 32'(g_q.size()), 32'd0);
    g_ce_div = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while payload byte 3 of a len=10 frame is on the wire
    clr_counts();
    for (int i = 0; i < 7; i++) push_byte(0, 8'h55);
    push_byte(0, 8'hD5);
    for (int k = 0; k < 4; k++) push_byte(0, 8'(k));
    request(0, 16'd10, 8'h00);
    t = 0;
    while (t < BOUND && g_dv_beats < 12) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("t5_reached_byte3", g_dv_beats, 12);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_dv",   {31'b0, g_dv},   32'd0);
    check("t5_txd",  {24'h0, g_txd},  32'd0);
    check("t5_busy", {31'b0, g_busy}, 32'd0);
    check("t5_fcnt", {16'h0, g_fcnt}, 32'd0);
    repeat (30) @(negedge clk);
    check("t5_no_done", g_done_cnt, 0);
    check("t5_qleft", 32'(g_q.size()), 32'd0);

    // Fresh frame after the abort
    clr_counts();
    push_frame(0, 3, 8'h7E, 0);
    request(0, 16'd3, 8'h7E);
    wait_done(0, "t6");
    check("t6_fcnt",  {16'h0, g_fcnt}, 32'd1);
    check("t6_beats", g_dv_beats, 11 + FCS_B);
    check("t6_qleft", 32'(g_q.size()), 32'd0);

    // len=2000 clamps to 1500; seed 00 wraps FF->00 at byte 256
    clr_counts();
    push_frame(0, 1500, 8'h00, 0);
    request(0, 16'd2000, 8'h00);
    wait_done(0, "t7");
    check("t7_fcnt",  {16'h0, g_fcnt}, 32'd2);
    check("t7_beats", g_dv_beats, 1508 + FCS_B);
    check("t7_ifg",   g_ifg_beats, 12);
    check("t7_qleft", 32'(g_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
